k005297_serialcntr_gen: RTL and testbench

//  Parametrised bit-serial up/down counter for the 005297 bubble controller datapath.

---
 rtl/k005297_serialcntr_gen_if.sv | 43 ++++
 rtl/k005297_serialcntr_gen.sv | 127 ++++++++++++
 tb/tb_k005297_serialcntr_gen.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/k005297_serialcntr_gen_if.sv
// Bundle for the 005297 bit-serial counter.
// Carries the bit-time enable, frame, step/load controls and all status outputs.
// Optional compare signals exist when K005297_SERIALCNTR_CMP_EN is defined.
interface k005297_serialcntr_gen_if #(
   parameter int WIDTH = 10
);
   logic             i_CLK2M_PCEN_n;
   logic             i_FRAME_n;
   logic             i_CNT_EN;
   logic             i_DOWN;
   logic             i_LOAD;
   logic [WIDTH-1:0] i_LOAD_DATA;
   logic             o_LSB;
   logic             o_BUSY;
   logic [WIDTH-1:0] o_VALUE;
   logic             o_ZERO;
   logic             o_TC;
   logic             o_FRAME_ERR;
`ifdef K005297_SERIALCNTR_CMP_EN
   logic [WIDTH-1:0] i_CMP_VAL;
   logic             o_MATCH;
`endif

   modport master (
      output i_CLK2M_PCEN_n, i_FRAME_n, i_CNT_EN, i_DOWN,
      output i_LOAD, i_LOAD_DATA,
`ifdef K005297_SERIALCNTR_CMP_EN
      output i_CMP_VAL,
      input  o_MATCH,
`endif
      input  o_LSB, o_BUSY, o_VALUE, o_ZERO, o_TC, o_FRAME_ERR
   );

   modport slave (
      input  i_CLK2M_PCEN_n, i_FRAME_n, i_CNT_EN, i_DOWN,
      input  i_LOAD, i_LOAD_DATA,
`ifdef K005297_SERIALCNTR_CMP_EN
      input  i_CMP_VAL,
      output o_MATCH,
`endif
      output o_LSB, o_BUSY, o_VALUE, o_ZERO, o_TC, o_FRAME_ERR
   );
endinterface

// File: rtl/k005297_serialcntr_gen.sv
// Bit-serial up/down counter: value recirculates LSB first through one
// full-adder cell, one bit per enabled bit-time (i_CLK2M_PCEN_n=0).
// Ports: i_MCLK, i_RST (sync, active-high), bus (slave modport) carrying
// frame/step/load controls and o_LSB/o_BUSY/o_VALUE/o_ZERO/o_TC/o_FRAME_ERR.
// Optional macro K005297_SERIALCNTR_CMP_EN adds i_CMP_VAL/o_MATCH compare.
module k005297_serialcntr_gen #(
   parameter int               WIDTH = 10,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input logic                     i_MCLK,
   input logic                     i_RST,
   k005297_serialcntr_gen_if.slave bus
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] ld_buf;
   logic [CW-1:0]    bitcnt;
   logic             carry;
   logic             en;
   logic             dir;
   logic             tc;
   logic             ferr;
   logic             ld_pend;

   logic             bit_in;
   logic             sum;
   logic             cout;
   logic             last;

   assign bit_in = sreg[0];
   assign sum    = bit_in ^ carry;
   // Down reuses the same cell: borrow propagates through zero bits.
   assign cout   = dir ? (~bit_in & carry) : (bit_in & carry);
   assign last   = (bitcnt == CW'(WIDTH - 1));

`ifdef K005297_SERIALCNTR_CMP_EN
   logic [WIDTH-1:0] cmp_sh;
   logic             cmp_ok;
   logic             match;
`endif

   always_ff @(posedge i_MCLK) begin
      if (i_RST) begin
         state   <= IDLE;
         sreg    <= INIT;
         ld_buf  <= '0;
         bitcnt  <= '0;
         carry   <= 1'b0;
         en      <= 1'b0;
         dir     <= 1'b0;
         tc      <= 1'b0;
         ferr    <= 1'b0;
         ld_pend <= 1'b0;
`ifdef K005297_SERIALCNTR_CMP_EN
         cmp_sh  <= '0;
         cmp_ok  <= 1'b0;
         match   <= 1'b0;
`endif
      end else if (!bus.i_CLK2M_PCEN_n) begin
         unique case (state)
            IDLE: begin
               tc <= 1'b0;
`ifdef K005297_SERIALCNTR_CMP_EN
               match <= 1'b0;
`endif
               // A load (fresh or deferred from a frame) wins over
               // frame start and suppresses it silently.
               if (ld_pend || bus.i_LOAD) begin
                  sreg    <= bus.i_LOAD ? bus.i_LOAD_DATA : ld_buf;
                  ld_pend <= 1'b0;
               end else if (!bus.i_FRAME_n) begin
                  state  <= SHIFT;
                  en     <= bus.i_CNT_EN;
                  dir    <= bus.i_DOWN;
                  carry  <= bus.i_CNT_EN;
                  bitcnt <= '0;
`ifdef K005297_SERIALCNTR_CMP_EN
                  cmp_sh <= bus.i_CMP_VAL;
                  cmp_ok <= 1'b1;
`endif
               end
            end
            SHIFT: begin
               sreg   <= {sum, sreg[WIDTH-1:1]};
               carry  <= cout;
               bitcnt <= bitcnt + CW'(1);
`ifdef K005297_SERIALCNTR_CMP_EN
               cmp_sh <= cmp_sh >> 1;
               cmp_ok <= cmp_ok & (sum == cmp_sh[0]);
`endif
               if (!bus.i_FRAME_n) begin
                  ferr <= 1'b1;
               end
               if (bus.i_LOAD) begin
                  ld_pend <= 1'b1;
                  ld_buf  <= bus.i_LOAD_DATA;
               end
               if (last) begin
                  state <= IDLE;
                  tc    <= en & cout;
`ifdef K005297_SERIALCNTR_CMP_EN
                  match <= cmp_ok & (sum == cmp_sh[0]);
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.o_LSB       = sreg[0];
   assign bus.o_BUSY      = (state == SHIFT);
   assign bus.o_VALUE     = sreg;
   assign bus.o_ZERO      = (state == IDLE) && (sreg == '0);
   assign bus.o_TC        = tc;
   assign bus.o_FRAME_ERR = ferr;
`ifdef K005297_SERIALCNTR_CMP_EN
   assign bus.o_MATCH     = match;
`endif
endmodule

// File: tb/tb_k005297_serialcntr_gen.sv
// Directed bench for k005297_serialcntr_gen, WIDTH=10, INIT=0.
// Hand-computed expectations for frames, loads, stalls, errors and reset.
module tb_k005297_serialcntr_gen;
   localparam int W = 10;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   k005297_serialcntr_gen_if #(.WIDTH(W)) bus ();

   k005297_serialcntr_gen #(
      .WIDTH(W),
      .INIT (10'h000)
   ) dut (
      .i_MCLK(clk),
      .i_RST (rst),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [W-1:0] d);
      bus.i_CLK2M_PCEN_n = 1'b0;
      bus.i_LOAD         = 1'b1;
      bus.i_LOAD_DATA    = d;
      cyc();
      bus.i_LOAD = 1'b0;
   endtask

   task automatic start(input logic e, input logic dn);
      bus.i_CLK2M_PCEN_n = 1'b0;
      bus.i_CNT_EN       = e;
      bus.i_DOWN         = dn;
      bus.i_FRAME_n      = 1'b0;
      cyc();
      bus.i_FRAME_n = 1'b1;
   endtask

   task automatic run_frame(input logic e, input logic dn, input bit tog,
                            output int nbits, output logic tc_end,
                            output logic tc_next, output logic m_end);
      logic [W-1:0] snap;
      int           stall_bad;
      bit           ph;
      bit           done;
      start(e, dn);
      chk("busy_rise", bus.o_BUSY, 1);
      nbits     = 0;
      stall_bad = 0;
      ph        = 1'b1;
      done      = 1'b0;
      for (int k = 0; k < 200 && !done; k++) begin
         bus.i_CLK2M_PCEN_n = tog ? ph : 1'b0;
         ph   = ~ph;
         snap = bus.o_VALUE;
         cyc();
         if (bus.i_CLK2M_PCEN_n) begin
            if (bus.o_VALUE !== snap || bus.o_BUSY !== 1'b1) stall_bad++;
         end else begin
            nbits++;
         end
         if (!bus.o_BUSY) done = 1'b1;
      end
      if (!done) chk("timeout", 1, 0);
      chk("stall", stall_bad, 0);
      tc_end = bus.o_TC;
`ifdef K005297_SERIALCNTR_CMP_EN
      m_end = bus.o_MATCH;
`else
      m_end = 1'b0;
`endif
      bus.i_CLK2M_PCEN_n = 1'b0;
      cyc();
      tc_next = bus.o_TC;
   endtask

   int   nb;
   logic te;
   logic tn;
   logic me;

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst                = 1'b1;
      bus.i_CLK2M_PCEN_n = 1'b1;
      bus.i_FRAME_n      = 1'b1;
      bus.i_CNT_EN       = 1'b0;
      bus.i_DOWN         = 1'b0;
      bus.i_LOAD         = 1'b0;
      bus.i_LOAD_DATA    = '0;
`ifdef K005297_SERIALCNTR_CMP_EN
      bus.i_CMP_VAL      = '0;
`endif
      cyc();
      cyc();
      rst = 1'b0;

      // reset state
      chk("rst_val", bus.o_VALUE, 0);
      chk("rst_zero", bus.o_ZERO, 1);
      chk("rst_busy", bus.o_BUSY, 0);
      chk("rst_tc", bus.o_TC, 0);
      chk("rst_ferr", bus.o_FRAME_ERR, 0);

      // three up frames with stalled cycles interleaved
      for (int f = 0; f < 3; f++) begin
         run_frame(1'b1, 1'b0, 1'b1, nb, te, tn, me);
         chk("up_bits", nb, W);
         chk("up_tc", te, 0);
      end
      chk("up3_val", bus.o_VALUE, 3);
      chk("up3_zero", bus.o_ZERO, 0);

      // wrap up from all-ones, then borrow down from zero
      load(10'h3FF);
      chk("ld_3ff", bus.o_VALUE, 10'h3FF);
      run_frame(1'b1, 1'b0, 1'b0, nb, te, tn, me);
      chk("wrap_bits", nb, W);
      chk("wrap_tc", te, 1);
      chk("wrap_tc_clr", tn, 0);
      chk("wrap_val", bus.o_VALUE, 0);
      chk("wrap_zero", bus.o_ZERO, 1);
      run_frame(1'b1, 1'b1, 1'b0, nb, te, tn, me);
      chk("dn_tc", te, 1);
      chk("dn_tc_clr", tn, 0);
      chk("dn_val", bus.o_VALUE, 10'h3FF);

      // disabled-step frame recirculates unchanged
      load(10'h155);
      run_frame(1'b0, 1'b0, 1'b0, nb, te, tn, me);
      chk("noen_bits", nb, W);
      chk("noen_tc", te, 0);
      chk("noen_val", bus.o_VALUE, 10'h155);

      // load and frame start together: load wins, no frame, no error
      bus.i_CNT_EN  = 1'b1;
      bus.i_FRAME_n = 1'b0;
      load(10'h0AA);
      bus.i_FRAME_n = 1'b1;
      chk("ldfr_busy", bus.o_BUSY, 0);
      chk("ldfr_val", bus.o_VALUE, 10'h0AA);
      chk("ldfr_ferr", bus.o_FRAME_ERR, 0);
      cyc();
      chk("ldfr_busy2", bus.o_BUSY, 0);

      // frame start while busy, load mid-frame deferred
      start(1'b1, 1'b0);
      for (int k = 0; k < 4; k++) cyc();
      bus.i_FRAME_n = 1'b0;
      cyc();
      bus.i_FRAME_n = 1'b1;
      chk("ferr_set", bus.o_FRAME_ERR, 1);
      chk("ferr_busy", bus.o_BUSY, 1);
      bus.i_LOAD      = 1'b1;
      bus.i_LOAD_DATA = 10'h123;
      cyc();
      bus.i_LOAD = 1'b0;
      for (int k = 0; k < 3; k++) cyc();
      chk("mid_busy9", bus.o_BUSY, 1);
      cyc();
      chk("mid_busy_fall", bus.o_BUSY, 0);
      chk("mid_val", bus.o_VALUE, 10'h0AB);
      cyc();
      chk("pend_val", bus.o_VALUE, 10'h123);
      chk("ferr_sticky", bus.o_FRAME_ERR, 1);

      // reset mid-frame
      start(1'b1, 1'b0);
      for (int k = 0; k < 5; k++) cyc();
      chk("pre_rst_busy", bus.o_BUSY, 1);
      rst                = 1'b1;
      bus.i_CLK2M_PCEN_n = 1'b1;
      cyc();
      rst                = 1'b0;
      bus.i_CLK2M_PCEN_n = 1'b0;
      chk("mrst_busy", bus.o_BUSY, 0);
      chk("mrst_val", bus.o_VALUE, 0);
      chk("mrst_ferr", bus.o_FRAME_ERR, 0);
      cyc();
      chk("mrst_busy2", bus.o_BUSY, 0);

`ifdef K005297_SERIALCNTR_CMP_EN
      load(10'd4);
      bus.i_CMP_VAL = 10'd5;
      run_frame(1'b1, 1'b0, 1'b0, nb, te, tn, me);
      chk("cmp_hit", me, 1);
      chk("cmp_val", bus.o_VALUE, 5);
      chk("cmp_clr", bus.o_MATCH, 0);
      bus.i_CMP_VAL = 10'd7;
      run_frame(1'b1, 1'b0, 1'b0, nb, te, tn, me);
      chk("cmp_miss", me, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
